// File: rtl/hpu_pkg.sv
// Shared HPU types for the CSR bus: operation encoding, bus request/response
// structs and the hub read latency used by every CSR bus master.
package hpu_pkg;

  localparam int unsigned CSR_RD_LAT = 2;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned ROB_ID_W   = 6;

  typedef logic [11:0]         csr_addr_t;
  typedef logic [XLEN-1:0]     data_t;
  typedef logic [ROB_ID_W-1:0] rob_id_t;

  typedef enum logic [1:0] {
    CSR_RW = 2'd0,
    CSR_RS = 2'd1,
    CSR_RC = 2'd2
  } csr_op_e;

  typedef struct packed {
    csr_addr_t raddr;
    logic      wr_en;
    csr_addr_t waddr;
    data_t     wdata;
  } csr_bus_req_t;

  typedef struct packed {
    data_t rdata;
  } csr_bus_rsp_t;

  // The top two address bits set to 2'b11 mark a read-only CSR.
  function automatic logic csr_is_read_only(input csr_addr_t addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/hpu_csr_modify.sv
// Read-modify-write data path for CSR instructions: produces the value to
// write back from the operation type, the old CSR value and the operand.
module hpu_csr_modify
  import hpu_pkg::*;
(
  input  csr_op_e op_i,
  input  data_t   old_i,
  input  data_t   data_i,
  output data_t   wdata_o
);

  // NOTE: every output of an always_comb block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    wdata_o = data_i;
    case (op_i)
      CSR_RS:  wdata_o = old_i | data_i;
      CSR_RC:  wdata_o = old_i & ~data_i;
      default: wdata_o = data_i;
    endcase
  end

endmodule

// File: rtl/hpu_csr_initiator.sv
// Pipeline-side CSR bus master: runs one CSRRW/CSRRS/CSRRC at a time through
// read, modify and write against the CSR hub and returns the old value.
module hpu_csr_initiator
  import hpu_pkg::*;
#(
  parameter int unsigned RD_LAT = CSR_RD_LAT
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         csr_op_vld_i,
  output logic         csr_op_rdy_o,
  input  csr_op_e      csr_op_type_i,
  input  csr_addr_t    csr_op_addr_i,
  input  data_t        csr_op_data_i,
  input  logic         csr_op_skip_rd_i,
  input  logic         csr_op_skip_wr_i,
  input  rob_id_t      csr_op_tag_i,
  input  logic         flush_i,
  output csr_bus_req_t csr__bus_req_o,
  input  csr_bus_rsp_t csr__bus_rsp_i,
  output logic         wb_vld_o,
  input  logic         wb_rdy_i,
  output rob_id_t      wb_tag_o,
  output data_t        wb_data_o,
  output logic         wb_exc_o
);

  localparam int unsigned CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  csr_op_e          type_q, type_d;
  csr_addr_t        addr_q, addr_d;
  data_t            data_q, data_d;
  data_t            old_q, old_d;
  rob_id_t          tag_q, tag_d;
  logic             need_wr_q, need_wr_d;
  logic             ill_q, ill_d;

  csr_bus_req_t     req_q, req_d;
  logic             wb_vld_q, wb_vld_d;
  rob_id_t          wb_tag_q, wb_tag_d;
  data_t            wb_data_q, wb_data_d;
  logic             wb_exc_q, wb_exc_d;

  logic             accept;
  logic             need_wr_in;
  logic             ill_in;
  data_t            wdata;

  assign csr_op_rdy_o = (state_q == ST_IDLE);
  assign accept       = csr_op_vld_i & csr_op_rdy_o & ~flush_i;
  assign need_wr_in   = (csr_op_type_i == CSR_RW) | ~csr_op_skip_wr_i;
  assign ill_in       = csr_is_read_only(csr_op_addr_i) & need_wr_in;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    type_d    = type_q;
    addr_d    = addr_q;
    data_d    = data_q;
    old_d     = old_q;
    tag_d     = tag_q;
    need_wr_d = need_wr_q;
    ill_d     = ill_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          type_d    = csr_op_type_i;
          addr_d    = csr_op_addr_i;
          data_d    = csr_op_data_i;
          tag_d     = csr_op_tag_i;
          need_wr_d = need_wr_in;
          ill_d     = ill_in;
          old_d     = '0;
          cnt_d     = CNT_W'(RD_LAT);
          if (csr_op_skip_rd_i && (csr_op_type_i == CSR_RW)) begin
            state_d = ill_in ? ST_RESP : ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end

      ST_READ: begin
        // The hub holds rdata valid only on the last cycle of the read window.
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          old_d   = csr__bus_rsp_i.rdata;
          state_d = (need_wr_q & ~ill_q) ? ST_WRITE : ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_WRITE: state_d = flush_i ? ST_IDLE : ST_RESP;

      ST_RESP: begin
        if (flush_i || wb_rdy_i) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  hpu_csr_modify u_modify (
    .op_i    (type_d),
    .old_i   (old_d),
    .data_i  (data_d),
    .wdata_o (wdata)
  );

  // Outputs are registered: decode them from the state being entered.
  always_comb begin
    req_d = '0;
    if (state_d == ST_READ) begin
      req_d.raddr = addr_d;
    end
    if (state_d == ST_WRITE) begin
      req_d.wr_en = 1'b1;
      req_d.waddr = addr_d;
      req_d.wdata = wdata;
    end
    wb_vld_d  = (state_d == ST_RESP);
    wb_tag_d  = wb_vld_d ? tag_d : '0;
    wb_data_d = wb_vld_d ? old_d : '0;
    wb_exc_d  = wb_vld_d & ill_d;
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      type_q    <= CSR_RW;
      addr_q    <= '0;
      data_q    <= '0;
      old_q     <= '0;
      tag_q     <= '0;
      need_wr_q <= 1'b0;
      ill_q     <= 1'b0;
      req_q     <= '0;
      wb_vld_q  <= 1'b0;
      wb_tag_q  <= '0;
      wb_data_q <= '0;
      wb_exc_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      type_q    <= type_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      old_q     <= old_d;
      tag_q     <= tag_d;
      need_wr_q <= need_wr_d;
      ill_q     <= ill_d;
      req_q     <= req_d;
      wb_vld_q  <= wb_vld_d;
      wb_tag_q  <= wb_tag_d;
      wb_data_q <= wb_data_d;
      wb_exc_q  <= wb_exc_d;
    end
  end

  assign csr__bus_req_o = req_q;
  assign wb_vld_o       = wb_vld_q;
  assign wb_tag_o       = wb_tag_q;
  assign wb_data_o      = wb_data_q;
  assign wb_exc_o       = wb_exc_q;

endmodule

// File: tb/tb_hpu_csr_initiator.sv
// Scoreboard bench for hpu_csr_initiator: a hub model with fixed read latency,
// expected reads/writes/writebacks queued at issue and compared on the bus.
module tb_hpu_csr_initiator;
  import hpu_pkg::*;

  localparam int RD_LAT = CSR_RD_LAT;

  typedef struct {
    csr_addr_t addr;
    int        cyc;
    int        len;
  } rd_exp_t;

  typedef struct {
    csr_addr_t addr;
    data_t     data;
    int        cyc;
  } wr_exp_t;

  typedef struct {
    rob_id_t tag;
    data_t   data;
    logic    exc;
    int      cyc;
  } wb_exp_t;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         op_vld = 1'b0;
  logic         op_rdy;
  csr_op_e      op_type = CSR_RW;
  csr_addr_t    op_addr = '0;
  data_t        op_data = '0;
  logic         op_skip_rd = 1'b0;
  logic         op_skip_wr = 1'b0;
  rob_id_t      op_tag = '0;
  logic         flush = 1'b0;
  csr_bus_req_t bus_req;
  csr_bus_rsp_t bus_rsp;
  logic         wb_vld;
  logic         wb_rdy = 1'b1;
  rob_id_t      wb_tag;
  data_t        wb_data;
  logic         wb_exc;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit hub_init = 1'b1;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  wb_exp_t wb_q[$];
  data_t   ref_mem[csr_addr_t];

  data_t hub_mem [4096];
  data_t rd_pipe [RD_LAT];

  hpu_csr_initiator #(.RD_LAT(RD_LAT)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .csr_op_vld_i     (op_vld),
    .csr_op_rdy_o     (op_rdy),
    .csr_op_type_i    (op_type),
    .csr_op_addr_i    (op_addr),
    .csr_op_data_i    (op_data),
    .csr_op_skip_rd_i (op_skip_rd),
    .csr_op_skip_wr_i (op_skip_wr),
    .csr_op_tag_i     (op_tag),
    .flush_i          (flush),
    .csr__bus_req_o   (bus_req),
    .csr__bus_rsp_i   (bus_rsp),
    .wb_vld_o         (wb_vld),
    .wb_rdy_i         (wb_rdy),
    .wb_tag_o         (wb_tag),
    .wb_data_o        (wb_data),
    .wb_exc_o         (wb_exc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic data_t init_val(input csr_addr_t a);
    case (a)
      12'h320: return 32'h0000_0004;
      12'hF11: return 32'h0000_060A;
      12'h300: return 32'hFFFF_00FF;
      12'h341: return 32'h8000_0004;
      12'hC00: return 32'h0000_1234;
      default: return 32'h0;
    endcase
  endfunction

  function automatic data_t ref_rd(input csr_addr_t a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Hub: read data appears RD_LAT edges after raddr; writes land at the edge.
  always @(posedge clk) begin
    if (hub_init) begin
      for (int i = 0; i < 4096; i++) hub_mem[i] <= init_val(12'(i));
    end else if (bus_req.wr_en === 1'b1) begin
      hub_mem[bus_req.waddr] <= bus_req.wdata;
    end
    rd_pipe[0] <= hub_mem[bus_req.raddr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign bus_rsp.rdata = rd_pipe[RD_LAT-1];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rdy"}, op_rdy, 1);
    check({pfx, "_req"}, bus_req, 0);
    check({pfx, "_wb_vld"}, wb_vld, 0);
    check({pfx, "_wb_tag"}, wb_tag, 0);
    check({pfx, "_wb_data"}, wb_data, 0);
    check({pfx, "_wb_exc"}, wb_exc, 0);
  endtask

  // Monitor: compare bus and writeback activity against the queues.
  csr_addr_t prev_raddr = '0;
  logic      prev_vld = 1'b0;
  int        rd_len = 0;
  rd_exp_t   cur_rd;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus_req.raddr != '0) begin
        if (prev_raddr == '0) begin
          if (rd_q.size() == 0) begin
            check("unexpected_read", bus_req.raddr, 0);
          end else begin
            cur_rd = rd_q.pop_front();
            check("rd_addr", bus_req.raddr, cur_rd.addr);
            check("rd_cycle", cyc, cur_rd.cyc);
          end
          rd_len = 0;
        end
        rd_len++;
      end else if (prev_raddr != '0) begin
        check("rd_len", rd_len, cur_rd.len);
      end
      prev_raddr = bus_req.raddr;

      if (bus_req.wr_en) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", {bus_req.waddr, bus_req.wdata}, 0);
        end else begin
          check("wr_addr", bus_req.waddr, wr_q[0].addr);
          check("wr_data", bus_req.wdata, wr_q[0].data);
          check("wr_cycle", cyc, wr_q[0].cyc);
          void'(wr_q.pop_front());
        end
      end else begin
        check("bus_wr_idle", {bus_req.waddr, bus_req.wdata}, 0);
      end

      if (wb_vld) begin
        if (wb_q.size() == 0) begin
          check("unexpected_wb", {wb_tag, wb_data}, 0);
        end else begin
          if (!prev_vld) check("wb_cycle", cyc, wb_q[0].cyc);
          check("wb_tag", wb_tag, wb_q[0].tag);
          check("wb_data", wb_data, wb_q[0].data);
          check("wb_exc", wb_exc, wb_q[0].exc);
          check("rdy_while_resp", op_rdy, 0);
          if (wb_rdy) void'(wb_q.pop_front());
        end
      end
      prev_vld = wb_vld;
    end
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!op_rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!op_rdy) check(tag, 0, 1);
  endtask

  // Drive one operation; kill_off/stall are cycle offsets from the accept cycle.
  task automatic issue(input csr_op_e t, input csr_addr_t a, input data_t d,
                       input bit srd, input bit swr, input rob_id_t tag,
                       input int flush_off, input int rst_off, input int stall);
    int    c, nread, kill, resp;
    bit    rd, needw, ill, wr;
    data_t old, wd;
    wait_idle("idle_before_issue");
    c     = cyc;
    rd    = !(srd && t == CSR_RW);
    needw = (t == CSR_RW) || !swr;
    ill   = (a[11:10] == 2'b11) && needw;
    wr    = needw && !ill;
    old   = rd ? ref_rd(a) : '0;
    nread = rd ? RD_LAT + 1 : 0;
    resp  = c + 1 + nread + (wr ? 1 : 0);
    kill  = (flush_off > 0) ? flush_off : rst_off;
    case (t)
      CSR_RS:  wd = old | d;
      CSR_RC:  wd = old & ~d;
      default: wd = d;
    endcase
    if (rd) rd_q.push_back('{a, c + 1, (kill > 0 && kill <= nread) ? kill : nread});
    if (wr && (kill == 0 || kill > nread)) begin
      wr_q.push_back('{a, wd, c + 1 + nread});
      ref_mem[a] = wd;
    end
    if (kill == 0) wb_q.push_back('{tag, old, ill, resp});

    if (stall > 0) wb_rdy = 1'b0;
    op_vld = 1'b1; op_type = t; op_addr = a; op_data = d;
    op_skip_rd = srd; op_skip_wr = swr; op_tag = tag;
    @(posedge clk); #1;
    op_vld = 1'b0;

    if (kill > 0) begin
      while (cyc < c + kill) begin @(posedge clk); #1; end
      if (flush_off > 0) flush = 1'b1; else rst_i = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; rst_i = 1'b0;
      if (rst_off > 0) check_reset_outputs("mid_read_rst");
      else check("rdy_after_flush", op_rdy, 1);
    end
    if (stall > 0) begin
      while (cyc < resp + stall) begin @(posedge clk); #1; end
      wb_rdy = 1'b1;
      @(posedge clk); #1;
      check("rdy_after_stall", op_rdy, 1);
    end
    wait_idle("op_done_timeout");
  endtask

  initial begin
    csr_op_e   rt;
    csr_addr_t addrs [6];
    addrs = '{12'h320, 12'h340, 12'h341, 12'h300, 12'hF11, 12'hC00};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    hub_init = 1'b0;
    rst_i    = 1'b0;
    mon_en   = 1'b1;
    @(posedge clk); #1;

    issue(CSR_RS, 12'h320, 32'h1, 0, 0, 6'd1, 0, 0, 0);
    issue(CSR_RW, 12'h340, 32'hDEAD_BEEF, 1, 0, 6'd2, 0, 0, 0);
    issue(CSR_RC, 12'hF11, 32'h1, 0, 0, 6'd3, 0, 0, 0);
    issue(CSR_RS, 12'hF11, 32'h0, 0, 1, 6'd4, 0, 0, 0);
    issue(CSR_RW, 12'h340, 32'h1234_5678, 0, 0, 6'd5, 0, 0, 0);
    issue(CSR_RC, 12'h300, 32'h0F0F_0F0F, 0, 0, 6'd6, 0, 0, 0);
    issue(CSR_RS, 12'h341, 32'h0, 0, 1, 6'd7, 0, 0, 0);
    issue(CSR_RW, 12'hC00, 32'h1, 1, 0, 6'd8, 0, 0, 0);

    // Flush during READ (cycle 2) and during WRITE (cycle 4).
    issue(CSR_RW, 12'h305, 32'h0000_AAAA, 0, 0, 6'd9, 2, 0, 0);
    issue(CSR_RS, 12'h305, 32'h0, 0, 1, 6'd10, 0, 0, 0);
    issue(CSR_RS, 12'h306, 32'h0000_00F0, 0, 0, 6'd11, 4, 0, 0);
    issue(CSR_RS, 12'h306, 32'h0, 0, 1, 6'd12, 0, 0, 0);

    // Writeback stalled five cycles, then an immediate follow-up request.
    issue(CSR_RW, 12'h340, 32'h0000_0055, 1, 0, 6'd13, 0, 0, 5);
    issue(CSR_RS, 12'h340, 32'h0, 0, 1, 6'd14, 0, 0, 0);

    // Flush in IDLE must block acceptance.
    op_vld = 1'b1; op_type = CSR_RS; op_addr = 12'h320; op_data = 32'h8;
    op_skip_rd = 1'b0; op_skip_wr = 1'b0; op_tag = 6'd15; flush = 1'b1;
    @(posedge clk); #1;
    op_vld = 1'b0; flush = 1'b0;
    check("flush_idle_rdy", op_rdy, 1);
    check("flush_idle_raddr", bus_req.raddr, 0);

    // Synchronous reset in the middle of a read.
    issue(CSR_RS, 12'h320, 32'h2, 0, 0, 6'd16, 0, 2, 0);
    issue(CSR_RS, 12'h320, 32'h0, 0, 1, 6'd17, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      rt = csr_op_e'($urandom_range(0, 2));
      issue(rt, addrs[$urandom_range(0, 5)], $urandom(),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            rob_id_t'(20 + i), 0, 0, 0);
    end

    repeat (5) @(posedge clk);
    #1;
    check("rd_queue_empty", rd_q.size(), 0);
    check("wr_queue_empty", wr_q.size(), 0);
    check("wb_queue_empty", wb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
